resp_stream_fifo: RTL and testbench
===================================

Name: resp_stream_fifo

Overview:
Parametrised successor to the single-clock response FIFO in the system controller path. It accepts variable-length multi-byte results from the ALU and single-byte register-file reads in the same cycle. It stores them atomically as a byte stream in LSB-first order and presents one byte per pop to the controller/Tx path. Added behaviour: variable result length, dual same-cycle push, occupancy count, sticky overflow and synchronous flush.

Parameters:
width, 8, byte width of the stream and of RD_out
RES_BYTES, 2, maximum bytes per ALU result; ALU_out is RES_BYTES*width wide
FDPTH, 8, FIFO depth in bytes; power of 2, and at least RES_BYTES+1

Ports:
CLK  input  1  system clock, rising edge
Reset  input  1  asynchronous active-low reset
ALU_valid  input  1  ALU result strobe, one cycle
ALU_out  input  RES_BYTES*width  ALU result; byte 0 is bits [width-1:0]
ALU_len  input  $clog2(RES_BYTES+1)  bytes to store (1..RES_BYTES), sampled with ALU_valid
RD_valid  input  1  register-read strobe
RD_out  input  width  register-read byte
RD_EN  input  1  pop request, one byte per cycle
Flush  input  1  synchronous clear
Data  output  width  popped byte
valid  output  1  one-cycle pulse qualifying Data
Embty  output  1  FIFO holds zero bytes
Full  output  1  FIFO holds FDPTH bytes
Count  output  $clog2(FDPTH+1)  bytes stored
Overflow  output  1  sticky; set when any push is rejected

Behaviour:
- Reset is asynchronous and active-low; CLK is the only clock. While Reset=0: pointers=0, Count=0, Data=0, valid=0, Embty=1, Full=0, Overflow=0.
- Storage: FDPTH x width register array. Write and read pointers are $clog2(FDPTH) bits and wrap modulo FDPTH.
- Free space for the cycle: free = FDPTH - Count, where Count is the registered value before this cycle's pop. A same-cycle pop does not add to free space.
- ALU push (priority source):
  - Accepted iff ALU_valid=1, 1<=ALU_len<=RES_BYTES and free>=ALU_len.
  - Writes bytes 0..ALU_len-1 to consecutive wrapped locations, byte 0 first, all in the same cycle.
  - Length outside 1..RES_BYTES: the push is rejected and Overflow is set.
- RD push:
  - Accepted iff RD_valid=1 and free>=(ALU bytes accepted this cycle)+1.
  - Written immediately after the ALU bytes in the same cycle.
- Atomicity: a push is never partially stored. If the free space is insufficient, the whole transaction of that source is dropped and Overflow is set. An ALU rejection does not block a fitting RD push.
- Pop:
  - RD_EN=1 with Count>0 in cycle N: the byte at the read pointer appears on Data with valid=1 in cycle N+1, and the read pointer advances.
  - RD_EN=1 with Count=0: ignored; valid=0, Data holds its previous value, no error.
- valid is exactly one cycle per accepted pop. Data holds its value between pops.
- Count update: Count_next = Count + pushed bytes - popped (0/1). Embty=(Count==0) and Full=(Count==FDPTH), both registered.
- Latency: a push in cycle N updates Embty, Full and Count in cycle N+1. A byte pushed in N can be popped at the earliest by RD_EN in N+1.
- Simultaneous push and pop: both take effect. A pop at Count=0 in the same cycle as a push is still ignored, so there is no fall-through.
- Flush=1: in the next cycle pointers=0, Count=0, Embty=1, Full=0, Overflow=0, valid=0. Flush overrides pushes and pops in the same cycle. Data is not cleared.
- Overflow clears only on Reset or Flush.
- Reset asserted mid-operation: immediate return to reset values; stored contents are discarded.

Test Plan:
- Reset then idle: Embty=1, Count=0, valid=0, Overflow=0 -> release Reset; still idle, no spurious valid.
- ALU_valid, ALU_out=16'hBEEF, ALU_len=2, then RD_EN for 2 cycles -> Data=8'hEF then 8'hBE with valid pulses; Count 2->1->0; Embty back to 1.
- Same cycle: ALU_out=16'h1234, ALU_len=2, plus RD_valid with RD_out=8'hA5 -> Count=3; pops give 34, 12, A5 in that order.
- Fill to Count=7, then ALU_len=2 and RD_valid=1 together -> ALU rejected, RD accepted; Count=8, Full=1, Overflow=1; Flush -> Count=0, Overflow=0.
- Pointer wrap: push and pop 20 single bytes 00..13 with RD_EN each cycle after the first -> output sequence 00..13 in order; Count never exceeds 1.
- RD_EN on empty together with RD_valid=8'h5A -> no valid that cycle; next RD_EN gives Data=5A. Assert Reset mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/resp_stream_fifo.sv
// resp_stream_fifo
//   Single-clock byte-stream FIFO for the controller response path. ALU results
//   can be several bytes long, and register-file reads are one byte. Both can be
//   pushed in the same cycle. Each source's bytes are stored atomically, LSB
//   first, and the FIFO presents one byte per accepted pop.
//
// Ports
//   CLK        system clock, rising edge
//   Reset      asynchronous active-low reset
//   ALU_valid  ALU result strobe
//   ALU_out    ALU result, byte 0 in bits [width-1:0]
//   ALU_len    number of ALU bytes to store (1..RES_BYTES)
//   RD_valid   register-read strobe
//   RD_out     register-read byte
//   RD_EN      pop request, one byte per cycle
//   Flush      synchronous clear of pointers, count and Overflow
//   Data       popped byte, held between pops
//   valid      one-cycle pulse qualifying Data
//   Embty      FIFO holds zero bytes
//   Full       FIFO holds FDPTH bytes
//   Count      bytes stored
//   Overflow   sticky, set when any push is rejected
module resp_stream_fifo #(
  parameter int width     = 8,
  parameter int RES_BYTES = 2,
  parameter int FDPTH     = 8
) (
  input  logic                             CLK,
  input  logic                             Reset,
  input  logic                             ALU_valid,
  input  logic [RES_BYTES*width-1:0]       ALU_out,
  input  logic [$clog2(RES_BYTES+1)-1:0]   ALU_len,
  input  logic                             RD_valid,
  input  logic [width-1:0]                 RD_out,
  input  logic                             RD_EN,
  input  logic                             Flush,
  output logic [width-1:0]                 Data,
  output logic                             valid,
  output logic                             Embty,
  output logic                             Full,
  output logic [$clog2(FDPTH+1)-1:0]       Count,
  output logic                             Overflow
);

  localparam int LW = $clog2(RES_BYTES + 1);
  localparam int PW = $clog2(FDPTH);
  localparam int CW = $clog2(FDPTH + 1);

  localparam logic [LW-1:0] MAX_LEN = LW'(RES_BYTES);
  localparam logic [CW-1:0] DEPTH   = CW'(FDPTH);

  logic [width-1:0] mem_q [FDPTH];

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [width-1:0] data_q;
  logic             valid_q;
  logic             embty_q;
  logic             full_q;
  logic             ovf_q;

  logic [CW-1:0]    free;
  logic             len_ok;
  logic             alu_acc;
  logic [CW-1:0]    alu_n;
  logic             rd_acc;
  logic             pop;
  logic             ovf_set;
  logic [RES_BYTES-1:0] wen;
  logic [PW-1:0]    waddr [RES_BYTES];
  logic [PW-1:0]    rd_addr;

  // Free space is taken from the registered count, so a pop in the same cycle
  // does not make room for a push.
  always_comb begin
    free    = DEPTH - count_q;
    len_ok  = (ALU_len != '0) && (ALU_len <= MAX_LEN);
    alu_acc = ALU_valid && len_ok && (free >= CW'(ALU_len));
    alu_n   = alu_acc ? CW'(ALU_len) : '0;
    rd_acc  = RD_valid && (free >= alu_n + CW'(1));
    pop     = RD_EN && (count_q != '0);
    ovf_set = (ALU_valid && !alu_acc) || (RD_valid && !rd_acc);

    count_d = count_q + alu_n + CW'(rd_acc) - CW'(pop);
    wptr_d  = wptr_q + PW'(alu_n) + PW'(rd_acc);
    rptr_d  = rptr_q + PW'(pop);

    // The RD byte lands right after however many ALU bytes went in this cycle.
    rd_addr = wptr_q + PW'(alu_n);
    for (int unsigned i = 0; i < RES_BYTES; i++) begin
      wen[i]   = alu_acc && (LW'(i) < ALU_len);
      waddr[i] = wptr_q + PW'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (!Flush) begin
      for (int unsigned i = 0; i < RES_BYTES; i++) begin
        if (wen[i]) mem_q[waddr[i]] <= ALU_out[i*width +: width];
      end
      if (rd_acc) mem_q[rd_addr] <= RD_out;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      embty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (Flush) begin
      // Data keeps its last value across a flush.
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      embty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= pop;
      if (pop) data_q <= mem_q[rptr_q];
      embty_q <= (count_d == '0);
      full_q  <= (count_d == DEPTH);
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  assign Data     = data_q;
  assign valid    = valid_q;
  assign Embty    = embty_q;
  assign Full     = full_q;
  assign Count    = count_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_resp_stream_fifo.sv
// Scoreboard bench for resp_stream_fifo. The driver applies one cycle of
// stimulus per negedge and updates a queue-based reference of the stored
// stream. Bytes due to be popped are queued for a monitor that checks the
// DUT after every rising edge.
module tb_resp_stream_fifo;

  localparam int W  = 8;
  localparam int RB = 2;
  localparam int FD = 8;
  localparam int LW = $clog2(RB + 1);
  localparam int CW = $clog2(FD + 1);

  logic              CLK = 1'b0;
  logic              Reset = 1'b0;
  logic              ALU_valid = 1'b0;
  logic [RB*W-1:0]   ALU_out = '0;
  logic [LW-1:0]     ALU_len = '0;
  logic              RD_valid = 1'b0;
  logic [W-1:0]      RD_out = '0;
  logic              RD_EN = 1'b0;
  logic              Flush = 1'b0;
  logic [W-1:0]      Data;
  logic              valid;
  logic              Embty;
  logic              Full;
  logic [CW-1:0]     Count;
  logic              Overflow;

  resp_stream_fifo #(.width(W), .RES_BYTES(RB), .FDPTH(FD)) dut (
    .CLK(CLK), .Reset(Reset),
    .ALU_valid(ALU_valid), .ALU_out(ALU_out), .ALU_len(ALU_len),
    .RD_valid(RD_valid), .RD_out(RD_out), .RD_EN(RD_EN), .Flush(Flush),
    .Data(Data), .valid(valid), .Embty(Embty), .Full(Full),
    .Count(Count), .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference: the stored byte stream, the sticky error and the last popped byte.
  byte unsigned mq[$];
  byte unsigned exq[$];
  bit           movf = 1'b0;
  byte unsigned mdata = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit av, input logic [RB*W-1:0] ad, input int al,
                      input bit rv, input logic [W-1:0] rdat, input bit re,
                      input bit fl);
    int free;
    int n;
    bit aacc;
    @(negedge CLK);
    ALU_valid = av; ALU_out = ad; ALU_len = al[LW-1:0];
    RD_valid = rv; RD_out = rdat; RD_EN = re; Flush = fl;
    if (fl) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      free = FD - mq.size();
      n    = 0;
      aacc = av && al >= 1 && al <= RB && free >= al;
      if (av && !aacc) movf = 1'b1;
      if (re && mq.size() > 0) begin
        mdata = mq.pop_front();
        exq.push_back(mdata);
      end
      if (aacc) begin
        for (int k = 0; k < al; k++) mq.push_back(ad[k*W +: W]);
        n = al;
      end
      if (rv) begin
        if (free >= n + 1) mq.push_back(rdat);
        else movf = 1'b1;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, '0, 0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, 32'(Count), 32'd0);
    chk({tag, "_embty"}, 32'(Embty), 32'd1);
    chk({tag, "_full"},  32'(Full), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_ovf"},   32'(Overflow), 32'd0);
    chk({tag, "_data"},  32'(Data), 32'd0);
  endtask

  // Monitor: exactly one expected byte may be pending per cycle.
  initial begin
    byte unsigned e;
    forever begin
      @(posedge CLK);
      #1;
      if (Reset) begin
        chk("valid", 32'(valid), 32'(exq.size() != 0));
        if (exq.size() != 0) begin
          e = exq.pop_front();
          chk("pop_data", 32'(Data), 32'(e));
        end
        chk("data_hold", 32'(Data), 32'(mdata));
        chk("count", 32'(Count), 32'(mq.size()));
        chk("embty", 32'(Embty), 32'(mq.size() == 0));
        chk("full",  32'(Full), 32'(mq.size() == FD));
        chk("overflow", 32'(Overflow), 32'(movf));
      end
    end
  end

  initial begin
    // Reset held, then released: idle state throughout.
    repeat (2) @(posedge CLK);
    #1 check_reset_outputs("rst");
    @(negedge CLK) Reset = 1'b1;
    repeat (3) idle();

    // Two-byte ALU result popped LSB first.
    step(1'b1, 16'hBEEF, 2, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 0, 1'b0, '0, 1'b1, 1'b0);
    idle();

    // ALU and RD in the same cycle: RD byte goes after the ALU bytes.
    step(1'b1, 16'h1234, 2, 1'b1, 8'hA5, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 0, 1'b0, '0, 1'b1, 1'b0);
    idle();

    // Fill to 7, then ALU(2)+RD: ALU rejected, RD still fits.
    for (int i = 0; i < 7; i++) step(1'b0, '0, 0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 16'hCAFE, 2, 1'b1, 8'h77, 1'b0, 1'b0);
    @(posedge CLK); #2;
    chk("fill_count", 32'(Count), 32'd8);
    chk("fill_full", 32'(Full), 32'd1);
    chk("fill_ovf", 32'(Overflow), 32'd1);
    step(1'b1, 16'h0101, 1, 1'b0, '0, 1'b1, 1'b1);
    @(posedge CLK); #2;
    chk("flush_count", 32'(Count), 32'd0);
    chk("flush_ovf", 32'(Overflow), 32'd0);
    idle();

    // Invalid lengths reject the ALU push but not the RD push.
    step(1'b1, 16'h5555, 0, 1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 16'h6666, 3, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 0, 1'b0, '0, 1'b0, 1'b1);

    // Pointer wrap with streaming single bytes.
    step(1'b0, '0, 0, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) step(1'b0, '0, 0, 1'b1, 8'(i), 1'b1, 1'b0);
    step(1'b0, '0, 0, 1'b0, '0, 1'b1, 1'b0);
    idle();

    // Pop on empty with a simultaneous push: no fall-through.
    step(1'b0, '0, 0, 1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b0, '0, 0, 1'b0, '0, 1'b1, 1'b0);
    idle();

    // Randomised traffic, including bad lengths, overflow and flush.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) != 0, 16'($urandom), int'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 39) == 0);
    end

    // Asynchronous reset in the middle of a stream.
    step(1'b1, 16'h9988, 2, 1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, '0, 0, 1'b0, '0, 1'b1, 1'b0);
    #2 Reset = 1'b0;
    #1 check_reset_outputs("async_rst");
    mq.delete();
    exq.delete();
    movf  = 1'b0;
    mdata = 8'h00;
    @(negedge CLK) Reset = 1'b1;
    step(1'b0, '0, 0, 1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b0, '0, 0, 1'b0, '0, 1'b1, 1'b0);
    repeat (2) idle();

    chk("pending", 32'(exq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
